ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller driving an external dual-port RAM with registered read data
module ram_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              valid_q;
  logic              ovf_q;
  logic              unf_q;
  logic              push_ok;
  logic              pop_ok;

  // Gating with rst keeps the RAM untouched during reset whatever push/pop do.
  assign push_ok = push & ~full_q & ~rst;
  assign pop_ok  = pop & ~empty_q & ~rst;

  always_comb begin
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_next = count_q - CNT_ONE;
    end
  end

  // Status flags are flopped from the next count so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= AF_C);
      valid_q <= pop_ok;
      if (push && full_q) begin
        ovf_q <= 1'b1;
      end
      if (pop && empty_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign ram_wr_en   = push_ok;
  assign ram_wr_addr = wr_ptr;
  assign ram_din     = push_data;
  assign ram_rd_en   = pop_ok;
  assign ram_rd_addr = rd_ptr;

  assign pop_data    = ram_dout;
  assign pop_valid   = valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a queue reference model
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AF    = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       pop = 1'b0;
  logic [7:0] pop_data;
  logic       pop_valid, full, almost_full, empty, overflow, underflow;
  logic [4:0] count;
  logic       ram_wr_en, ram_rd_en;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_din, ram_dout;

  logic [7:0] mem [DEPTH];

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] mq[$];
  int         n_push = 0;
  int         n_pop = 0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       e_valid = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic       e_wr_en, e_rd_en;
  logic [3:0] e_wr_addr, e_rd_addr;
  logic       c_wr_en, c_rd_en;
  logic [3:0] c_wr_addr, c_rd_addr;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .almost_full(almost_full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // external RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
    if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
  end

  // One clock of traffic: drive at negedge, capture RAM-side outputs, advance model, settle after posedge.
  task automatic cycle(input logic p, input logic [7:0] d, input logic o);
    @(negedge clk);
    push = p; push_data = d; pop = o;
    #1;
    c_wr_en = ram_wr_en; c_wr_addr = ram_wr_addr;
    c_rd_en = ram_rd_en; c_rd_addr = ram_rd_addr;
    e_wr_en   = p && (mq.size() < DEPTH);
    e_rd_en   = o && (mq.size() > 0);
    e_wr_addr = 4'(n_push % DEPTH);
    e_rd_addr = 4'(n_pop % DEPTH);
    if (p && mq.size() == DEPTH) m_ovf = 1'b1;
    if (o && mq.size() == 0) m_unf = 1'b1;
    if (e_rd_en) begin
      e_data = mq.pop_front();
      n_pop++;
    end
    if (e_wr_en) begin
      mq.push_back(d);
      n_push++;
    end
    e_valid = e_rd_en;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input logic p, input logic o);
    @(negedge clk);
    rst = 1'b1; push = p; pop = o; push_data = 8'hEE;
    #1;
    c_wr_en = ram_wr_en; c_rd_en = ram_rd_en;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    mq.delete(); n_push = 0; n_pop = 0;
    m_ovf = 1'b0; m_unf = 1'b0; e_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_cycle(1'b1, 1'b1);
    total++; if (c_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", c_wr_en); end
    total++; if (c_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", c_rd_en); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({empty, full, almost_full} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b exp=100", {empty, full, almost_full}); end
    total++; if ({overflow, underflow, pop_valid} !== 3'b000) begin bad++; $display("FAIL reset_sticky got=%b exp=000", {overflow, underflow, pop_valid}); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      total++; if (c_wr_en !== 1'b1 || c_wr_addr !== 4'(i)) begin bad++; $display("FAIL fill_wr i=%0d got=%b/%0d exp=1/%0d", i, c_wr_en, c_wr_addr, i); end
      total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      total++; if (almost_full !== (i + 1 >= AF)) begin bad++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i + 1 >= AF)); end
      total++; if (full !== (i + 1 == DEPTH)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i + 1 == DEPTH)); end
    end
  endtask

  task automatic test_overflow;
    cycle(1'b1, 8'hAA, 1'b0);
    total++; if (c_wr_en !== 1'b0) begin bad++; $display("FAIL ovf_wr_en got=%b exp=0", c_wr_en); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    // full with pop also high: push still refused
    cycle(1'b1, 8'hAB, 1'b1);
    total++; if (c_wr_en !== 1'b0 || c_rd_en !== 1'b1) begin bad++; $display("FAIL full_pushpop got=%b%b exp=01", c_wr_en, c_rd_en); end
    total++; if (count !== 5'd15 || pop_data !== 8'h00) begin bad++; $display("FAIL full_pushpop_data got=%0d/%h exp=15/00", count, pop_data); end
    cycle(1'b1, 8'h10, 1'b0);
  endtask

  task automatic test_drain;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      total++; if (pop_valid !== 1'b1 || pop_data !== e_data) begin bad++; $display("FAIL drain i=%0d got=%b/%h exp=1/%h", i, pop_valid, pop_data, e_data); end
    end
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_underflow_push;
    cycle(1'b1, 8'h55, 1'b1);
    total++; if (c_rd_en !== 1'b0 || c_wr_en !== 1'b1) begin bad++; $display("FAIL unf_en got=%b%b exp=01", c_rd_en, c_wr_en); end
    total++; if (underflow !== 1'b1 || count !== 5'd1 || pop_valid !== 1'b0) begin bad++; $display("FAIL unf_state got=%b/%0d/%b exp=1/1/0", underflow, count, pop_valid); end
    cycle(1'b0, 8'h00, 1'b1);
    total++; if (pop_valid !== 1'b1 || pop_data !== 8'h55) begin bad++; $display("FAIL unf_pop got=%b/%h exp=1/55", pop_valid, pop_data); end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_addr;
    while (n_push % DEPTH != 15) cycle(1'b1, 8'($urandom), 1'b0);
    while (mq.size() > 8) cycle(1'b0, 8'h00, 1'b1);
    while (mq.size() < 8) cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_addr = 4'(15 + i);
      cycle(1'b1, 8'($urandom), 1'b1);
      total++; if (c_wr_addr !== exp_addr || c_wr_en !== 1'b1 || c_rd_en !== 1'b1) begin bad++; $display("FAIL wrap_addr i=%0d got=%0d exp=%0d", i, c_wr_addr, exp_addr); end
      total++; if (count !== 5'd8 || pop_valid !== 1'b1 || pop_data !== e_data) begin bad++; $display("FAIL wrap_data i=%0d got=%0d/%h exp=8/%h", i, count, pop_data, e_data); end
    end
  endtask

  task automatic test_reset_midop;
    while (mq.size() > 6) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    total++; if (count !== 5'd5 || pop_valid !== 1'b1) begin bad++; $display("FAIL midop_pre got=%0d/%b exp=5/1", count, pop_valid); end
    reset_cycle(1'b0, 1'b1);
    total++; if (c_rd_en !== 1'b0) begin bad++; $display("FAIL midop_rd_en got=%b exp=0", c_rd_en); end
    total++; if (pop_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL midop_post got=%b/%0d/%b exp=0/0/1", pop_valid, count, empty); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL midop_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_random;
    int thr_push, thr_pop;
    for (int ph = 0; ph < 6; ph++) begin
      thr_push = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      thr_pop  = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 85 : 50;
      for (int k = 0; k < 80; k++) begin
        cycle($urandom_range(0, 99) < thr_push, 8'($urandom), $urandom_range(0, 99) < thr_pop);
        total++;
        if (c_wr_en !== e_wr_en || c_rd_en !== e_rd_en || (e_wr_en && c_wr_addr !== e_wr_addr) || (e_rd_en && c_rd_addr !== e_rd_addr)) begin
          bad++; $display("FAIL rnd_ram ph=%0d k=%0d got=%b%b/%0d/%0d exp=%b%b/%0d/%0d", ph, k, c_wr_en, c_rd_en, c_wr_addr, c_rd_addr, e_wr_en, e_rd_en, e_wr_addr, e_rd_addr);
        end
        total++;
        if (count !== 5'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || almost_full !== (mq.size() >= AF)) begin
          bad++; $display("FAIL rnd_status ph=%0d k=%0d got=%0d/%b%b%b exp=%0d", ph, k, count, full, empty, almost_full, mq.size());
        end
        total++;
        if (pop_valid !== e_valid || (e_valid && pop_data !== e_data) || overflow !== m_ovf || underflow !== m_unf) begin
          bad++; $display("FAIL rnd_out ph=%0d k=%0d got=%b/%h/%b%b exp=%b/%h/%b%b", ph, k, pop_valid, pop_data, overflow, underflow, e_valid, e_data, m_ovf, m_unf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow_push();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
